// File: rtl/apb_dpmem_pkg.sv
// Shared types for the APB dual-port memory slave: FSM states, wait counter and bus-sized vectors.
package apb_dpmem_pkg;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_ADDR_W = 32;
  localparam int PKG_STRB_W = PKG_DATA_W / 8;

  typedef logic [PKG_DATA_W-1:0] data_t;
  typedef logic [PKG_STRB_W-1:0] strb_t;
  typedef logic [PKG_ADDR_W-1:0] addr_t;

  typedef enum logic {IDLE, ACCESS} apb_state_e;

  typedef logic [3:0] wcnt_t;

  // Expand one strobe bit per byte lane into a full-width bit mask.
  function automatic data_t strb_mask(strb_t strb);
    data_t m;
    m = '0;
    for (int i = 0; i < PKG_STRB_W; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/apb_dpmem_ram.sv
// Dual-port word memory: byte-enable write and combinational read on port A,
// registered read-before-write port B for the local consumer.
module apb_dpmem_ram
  import apb_dpmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     a_we,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  input  logic [DATA_WIDTH/8-1:0]  a_strb,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  input  logic                     b_en,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  output logic [DATA_WIDTH-1:0]    b_rdata
);

  localparam int BW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] lane_mask;

  generate
    if (DATA_WIDTH == PKG_DATA_W) begin : g_pkg_mask
      assign lane_mask = strb_mask(a_strb);
    end else begin : g_loop_mask
      always_comb begin
        lane_mask = '0;
        for (int i = 0; i < BW; i++) begin
          lane_mask[8*i +: 8] = {8{a_strb[i]}};
        end
      end
    end
  endgenerate

  // Contents survive reset; only the sideband output register is cleared.
  always_ff @(posedge PCLK) begin
    if (a_we) begin
      mem[a_addr] <= (mem[a_addr] & ~lane_mask) | (a_wdata & lane_mask);
    end
  end

  assign a_rdata = mem[a_addr];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      b_rdata <= '0;
    end else if (b_en) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/apb_dpmem_slv.sv
// APB4 slave with programmable wait states over a dual-port memory plus a sideband read port.
// Optional address error reporting is enabled by defining APB_DPMEM_SLVERR_EN.
module apb_dpmem_slv
  import apb_dpmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [ADDR_WIDTH-1:0]    PADDR,
  input  logic                     PWRITE,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [DATA_WIDTH/8-1:0]  PSTRB,
  output logic                     PREADY,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PSLVERR,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int    BW      = DATA_WIDTH / 8;
  localparam int    LSB     = $clog2(BW);
  localparam int    IW      = $clog2(DEPTH);
  localparam wcnt_t WS_INIT = wcnt_t'(WAIT_STATES);

  apb_state_e            state;
  wcnt_t                 wcnt;
  logic                  wr_p0;
  logic                  err_p0;
  logic [IW-1:0]         word_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [BW-1:0]         strb_p0;

  logic                  setup;
  logic                  access_ok;
  logic [IW-1:0]         paddr_word;
  logic                  addr_err;
  logic [IW-1:0]         a_addr;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_we;
  logic                  last_nxt;
  logic                  err_nxt;
  logic                  rd_nxt;

  assign setup      = PSEL & ~PENABLE;
  assign access_ok  = PSEL & PENABLE;
  assign paddr_word = PADDR[LSB +: IW];

`ifdef APB_DPMEM_SLVERR_EN
  localparam logic [ADDR_WIDTH:0]   LIMIT   = (ADDR_WIDTH+1)'(DEPTH * BW);
  localparam logic [ADDR_WIDTH-1:0] LOWMASK = ADDR_WIDTH'(BW - 1);
  assign addr_err = ({1'b0, PADDR} >= LIMIT) | (|(PADDR & LOWMASK));
`else
  logic unused_paddr;
  assign unused_paddr = ^PADDR;
  assign addr_err     = 1'b0;
`endif

  // Port A addresses the live bus at setup, the latched word afterwards.
  assign a_addr = (state == IDLE) ? paddr_word : word_p0;
  assign a_we   = (state == ACCESS) & access_ok & PREADY & wr_p0 & ~err_p0 & ~PRESET;

  always_comb begin
    last_nxt = 1'b0;
    err_nxt  = err_p0;
    rd_nxt   = ~wr_p0;
    if (state == IDLE) begin
      last_nxt = setup & (WS_INIT == '0);
      err_nxt  = addr_err;
      rd_nxt   = ~PWRITE;
    end else begin
      last_nxt = access_ok & ~PREADY & (wcnt == wcnt_t'(1));
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      wcnt    <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= last_nxt;
      PSLVERR <= last_nxt & err_nxt;
      PRDATA  <= (last_nxt & rd_nxt & ~err_nxt) ? a_rdata : '0;
      case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            wcnt  <= WS_INIT;
          end
        end
        ACCESS: begin
          if (!access_ok || PREADY) begin
            state <= IDLE;
          end else begin
            wcnt <= wcnt - wcnt_t'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Setup-phase capture; later bus changes are ignored.
  always_ff @(posedge PCLK) begin
    if (state == IDLE && setup) begin
      wr_p0    <= PWRITE;
      err_p0   <= addr_err;
      word_p0  <= paddr_word;
      wdata_p0 <= PWDATA;
      strb_p0  <= PSTRB;
    end
  end

  apb_dpmem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .a_we   (a_we),
    .a_addr (a_addr),
    .a_wdata(wdata_p0),
    .a_strb (strb_p0),
    .a_rdata(a_rdata),
    .b_en   (rd_en),
    .b_addr (rd_addr),
    .b_rdata(rd_data)
  );

endmodule

// File: tb/tb_apb_dpmem_slv.sv
// Bench for apb_dpmem_slv: directed vector table, multi-cycle corner sequences and a randomized run
// against a byte-level memory model. Honours APB_DPMEM_SLVERR_EN when it is defined.
module tb_apb_dpmem_slv;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 32;
  localparam int WS    = 2;
  localparam int BYTES = DEPTH * DW / 8;
`ifdef APB_DPMEM_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          PCLK, PRESET, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, rd_en;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA, rd_data;
  logic [3:0]    PSTRB;
  logic [7:0]    rd_addr;

  apb_dpmem_slv #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a);
    return ERR_EN && ((a >= 32'(BYTES)) || (a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_err(a) ? 32'h0 : model[(a / 4) % DEPTH];
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    w = (a / 4) % DEPTH;
    if (!m_err(a)) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) model[w][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  // One APB transfer; checks access-phase length and that outputs stay 0 before PREADY.
  task automatic apb_xfer(input string name, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input bit scramble,
                          input bit sb, input logic [7:0] sb_addr,
                          output logic [31:0] rdata, output logic err);
    int  ncyc;
    bit  got;
    bit  early_bad;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (scramble) begin
      PADDR = $urandom; PWDATA = $urandom; PSTRB = 4'($urandom);
    end
    ncyc = 0; got = 1'b0; early_bad = 1'b0; rdata = '0; err = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge PCLK);
      ncyc++;
      if (PREADY) begin
        got = 1'b1; rdata = PRDATA; err = PSLVERR;
        if (sb) begin rd_en = 1'b1; rd_addr = sb_addr; end
      end else if (PRDATA != 0 || PSLVERR) begin
        early_bad = 1'b1;
      end
    end
    chk({name, " pready_seen"}, 64'(got), 64'(1));
    chk({name, " latency"}, 64'(ncyc), 64'(WS + 1));
    chk({name, " zero_before_ready"}, 64'(early_bad), 64'(0));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rd_en = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t        tv [13];
  logic [31:0] rd, old;
  logic        er;
  bit          saw_ready;

  initial begin
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0;
    rd_en = 0; rd_addr = 0; PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset PREADY", 64'(PREADY), 64'(0));
    chk("reset PSLVERR", 64'(PSLVERR), 64'(0));
    chk("reset PRDATA", 64'(PRDATA), 64'(0));
    chk("reset rd_data", 64'(rd_data), 64'(0));
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    tv[0]  = '{1, 32'h000, 32'h01020304, 4'hF, 32'h0, 0};
    tv[1]  = '{1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0, 0};
    tv[2]  = '{0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 0};
    tv[3]  = '{1, 32'h020, 32'h11223344, 4'hF, 32'h0, 0};
    tv[4]  = '{1, 32'h020, 32'hAABBCCDD, 4'h5, 32'h0, 0};
    tv[5]  = '{0, 32'h020, 32'h0,        4'h0, 32'h11BB33DD, 0};
    tv[6]  = '{1, 32'h024, 32'hCAFEBABE, 4'hF, 32'h0, 0};
    tv[7]  = '{1, 32'h024, 32'hFFFFFFFF, 4'h0, 32'h0, 0};
    tv[8]  = '{0, 32'h024, 32'h0,        4'h0, 32'hCAFEBABE, 0};
    tv[9]  = '{1, 32'h400, 32'h99999999, 4'hF, 32'h0, ERR_EN};
    tv[10] = '{0, 32'h000, 32'h0, 4'h0, ERR_EN ? 32'h01020304 : 32'h99999999, 0};
    tv[11] = '{0, 32'h002, 32'h0, 4'h0, ERR_EN ? 32'h0 : 32'h99999999, ERR_EN};
    tv[12] = '{0, 32'h410, 32'h0, 4'h0, ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN};

    for (int i = 0; i < 13; i++) begin
      apb_xfer($sformatf("vec%0d", i), tv[i].wr, tv[i].addr, tv[i].data, tv[i].strb,
               1'b0, 1'b0, 8'h0, rd, er);
      chk($sformatf("vec%0d PRDATA", i), 64'(rd), 64'(tv[i].exp_rd));
      chk($sformatf("vec%0d PSLVERR", i), 64'(er), 64'(tv[i].exp_err));
    end

    // Fill every word so the model and the memory agree from here on.
    for (int w = 0; w < DEPTH; w++) begin
      model[w] = $urandom;
      apb_xfer("fill", 1'b1, 32'(w * 4), model[w], 4'hF, 1'b0, 1'b0, 8'h0, rd, er);
    end

    // Sideband read on the same edge as a write commit returns the old word.
    old = model[5];
    apb_xfer("sb_write", 1'b1, 32'h14, 32'h55, 4'hF, 1'b0, 1'b1, 8'd5, rd, er);
    m_write(32'h14, 32'h55, 4'hF);
    @(negedge PCLK);
    chk("sb same-edge old", 64'(rd_data), 64'(old));
    rd_en = 1'b1; rd_addr = 8'd5;
    @(posedge PCLK); #1; rd_en = 1'b0;
    @(negedge PCLK);
    chk("sb new value", 64'(rd_data), 64'(32'h55));
    rd_addr = 8'd9;
    @(negedge PCLK);
    chk("sb hold", 64'(rd_data), 64'(32'h55));

    // Reset during the access phase of a write.
    old = model[6];
    saw_ready = 1'b0;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h18; PWDATA = 32'h77; PSTRB = 4'hF;
    @(posedge PCLK); #1; PENABLE = 1;
    @(negedge PCLK); saw_ready |= PREADY;
    PRESET = 1'b1;
    @(negedge PCLK); saw_ready |= PREADY;
    chk("midreset PREADY", 64'(PREADY), 64'(0));
    chk("midreset PRDATA", 64'(PRDATA), 64'(0));
    chk("midreset rd_data", 64'(rd_data), 64'(0));
    @(negedge PCLK); saw_ready |= PREADY;
    PRESET = 1'b0; PSEL = 0; PENABLE = 0;
    repeat (4) begin @(negedge PCLK); saw_ready |= PREADY; end
    chk("midreset no PREADY", 64'(saw_ready), 64'(0));
    apb_xfer("midreset readback", 1'b0, 32'h18, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0, rd, er);
    chk("midreset word unchanged", 64'(rd), 64'(old));

    // PSEL dropped mid-access.
    old = model[7];
    saw_ready = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h1C; PWDATA = 32'h1234; PSTRB = 4'hF;
    @(posedge PCLK); #1; PENABLE = 1;
    @(negedge PCLK); saw_ready |= PREADY;
    @(posedge PCLK); #1; PSEL = 0; PENABLE = 0;
    repeat (6) begin @(negedge PCLK); saw_ready |= PREADY; end
    // PENABLE dropped mid-access, then PSEL released.
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PADDR = 32'h1C;
    @(posedge PCLK); #1; PENABLE = 1;
    @(posedge PCLK); #1; PENABLE = 0;
    @(posedge PCLK); #1; PSEL = 0;
    repeat (6) begin @(negedge PCLK); saw_ready |= PREADY; end
    chk("abort no PREADY", 64'(saw_ready), 64'(0));
    @(posedge PCLK); #1;
    apb_xfer("abort readback", 1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0, rd, er);
    chk("abort word unchanged", 64'(rd), 64'(old));

    // Randomized traffic with bus changes during the access phase.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, d, exp_rd;
      logic [3:0]  s;
      logic [7:0]  sa;
      bit          w;
      w = 1'($urandom);
      a = $urandom_range(0, 2047) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom;
      s = 4'($urandom);
      exp_rd = w ? 32'h0 : m_read(a);
      apb_xfer($sformatf("rnd%0d", n), w, a, d, s, 1'b1, 1'b0, 8'h0, rd, er);
      chk($sformatf("rnd%0d PRDATA", n), 64'(rd), 64'(exp_rd));
      chk($sformatf("rnd%0d PSLVERR", n), 64'(er), 64'(m_err(a)));
      if (w) m_write(a, d, s);
      if ($urandom_range(0, 3) == 0) begin
        sa = 8'($urandom);
        rd_en = 1'b1; rd_addr = sa;
        @(posedge PCLK); #1; rd_en = 1'b0;
        @(negedge PCLK);
        chk($sformatf("rnd%0d rd_data", n), 64'(rd_data), 64'(model[sa]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
